// File: rtl/crc_serial_engine.sv
// Serial CRC engine: one message bit per clock while active_i is high, then the
// W-bit remainder is shifted out on crc_o qualified by valid_o.
module crc_serial_engine #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   TAPS      = 8'h44,
    parameter logic [W-1:0]   SEED      = 8'hD8,
    parameter bit             MSB_FIRST = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic data_i,
    input  logic active_i,
    output logic crc_o,
    output logic valid_o,
    output logic busy_o,
    output logic done_o
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    lfsr_q, lfsr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            crc_q, crc_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;

    // Feedback enters at the top stage; bit W-1 of TAPS has no stage above it.
    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] cur, input logic din);
        logic         fb;
        logic [W-1:0] nxt;
        fb       = din ^ cur[0];
        nxt[W-1] = fb;
        for (int i = 0; i < W - 1; i++) begin
            nxt[i] = cur[i+1] ^ (fb & TAPS[i]);
        end
        return nxt;
    endfunction

    function automatic logic [W-1:0] lfsr_shift(input logic [W-1:0] cur);
        if (MSB_FIRST) return {cur[W-2:0], 1'b0};
        else           return {1'b0, cur[W-1:1]};
    endfunction

    function automatic logic out_bit(input logic [W-1:0] cur);
        if (MSB_FIRST) return cur[W-1];
        else           return cur[0];
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            crc_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        crc_d   = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                lfsr_d = SEED;
                cnt_d  = '0;
                if (active_i) begin
                    lfsr_d  = lfsr_step(SEED, data_i);
                    state_d = CALC;
                end
            end
            CALC: begin
                if (active_i) begin
                    lfsr_d = lfsr_step(lfsr_q, data_i);
                end else begin
                    crc_d   = out_bit(lfsr_q);
                    lfsr_d  = lfsr_shift(lfsr_q);
                    cnt_d   = CW'(1);
                    valid_d = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (active_i) begin
                    // Abort: the bit on this edge is the first bit of a fresh frame.
                    lfsr_d  = lfsr_step(SEED, data_i);
                    cnt_d   = '0;
                    state_d = CALC;
                end else if (cnt_q < CW'(W)) begin
                    crc_d   = out_bit(lfsr_q);
                    lfsr_d  = lfsr_shift(lfsr_q);
                    cnt_d   = cnt_q + CW'(1);
                    valid_d = 1'b1;
                    done_d  = (cnt_q == CW'(W - 1));
                end else begin
                    lfsr_d  = SEED;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                lfsr_d  = SEED;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign crc_o   = crc_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q != IDLE);

endmodule
